// File: rtl/fifo_wb_dma.sv
// Wishbone master DMA: drains a first-word-fall-through FIFO into memory
// through single-beat classic Wishbone writes, one word per FETCH/WRITE pair.
module fifo_wb_dma #(
    parameter int FT_DATA_WIDTH = 32,
    parameter int LEN_WIDTH     = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,

    input  logic                     cfg_start_i,
    input  logic                     cfg_abort_i,
    input  logic [31:0]              cfg_base_i,
    input  logic [LEN_WIDTH-1:0]     cfg_len_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [LEN_WIDTH-1:0]     count_o,

    input  logic [FT_DATA_WIDTH-1:0] fifo_data_i,
    input  logic                     fifo_empty_i,
    output logic                     fifo_rd_o,

    output logic [31:0]              wbm_adr_o,
    output logic [31:0]              wbm_dat_o,
    output logic [3:0]               wbm_sel_o,
    output logic                     wbm_we_o,
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic [2:0]               wbm_cti_o,
    output logic [1:0]               wbm_bte_o,
    input  logic                     wbm_ack_i,
    input  logic                     wbm_err_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Current FSM state; kept as a named signal so checkers can bind to it.
    state_t state;
    state_t state_next;

    logic [31:0]          adr_q,   adr_d;
    logic [31:0]          dat_q,   dat_d;
    logic [LEN_WIDTH-1:0] len_q,   len_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [LEN_WIDTH-1:0] count_inc;
    logic                 err_q,   err_d;
    logic                 done_q,  done_d;
    logic                 cyc_q,   cyc_d;
    logic                 fifo_rd;
    logic [31:0]          dat_ext;

    always_comb begin
        dat_ext                    = '0;
        dat_ext[FT_DATA_WIDTH-1:0] = fifo_data_i;
    end

    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_next = state;
        adr_d      = adr_q;
        dat_d      = dat_q;
        len_d      = len_q;
        count_d    = count_q;
        err_d      = err_q;
        done_d     = 1'b0;
        fifo_rd    = 1'b0;

        case (state)
            IDLE: begin
                if (cfg_start_i) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    if (cfg_len_i != '0) begin
                        adr_d      = {cfg_base_i[31:2], 2'b00};
                        len_d      = cfg_len_i;
                        state_next = FETCH;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (cfg_abort_i) begin
                    state_next = IDLE;
                    done_d     = 1'b1;
                end else if (!fifo_empty_i) begin
                    fifo_rd    = 1'b1;
                    dat_d      = dat_ext;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // Error takes priority over a simultaneous ack; abort is not
                // looked at here so the beat in flight always terminates.
                if (wbm_err_i) begin
                    err_d      = 1'b1;
                    done_d     = 1'b1;
                    state_next = IDLE;
                end else if (wbm_ack_i) begin
                    count_d = count_inc;
                    adr_d   = adr_q + 32'd4;
                    if (count_inc == len_q) begin
                        done_d     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        cyc_d = (state_next == WRITE);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state   <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            state   <= state_next;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            len_q   <= len_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
            cyc_q   <= cyc_d;
        end
    end

    assign busy_o    = (state != IDLE);
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign count_o   = count_q;
    assign fifo_rd_o = fifo_rd;

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = 4'hF;
    assign wbm_we_o  = cyc_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;

endmodule
